// File: rtl/bus_arbiter_pkg.sv
// Shared types and round-robin helper for the N-channel bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;

  localparam int DEF_DATA_W = 64;
  localparam int STRB_W     = DEF_DATA_W / 8;
  localparam int MAX_NCH    = 8;

  // First set bit of valid at or after ptr, wrapping modulo nch (nch <= MAX_NCH).
  function automatic logic [2:0] rr_pick(input logic [MAX_NCH-1:0] valid,
                                         input logic [2:0] ptr,
                                         input int nch);
    logic [2:0] res;
    logic       found;
    logic [3:0] idx;
    res   = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_NCH; k++) begin
      if (k < nch) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= 4'(nch)) idx = idx - 4'(nch);
        if (!found && valid[idx[2:0]]) begin
          res   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_arbiter_picker.sv
// Combinational round-robin priority encoder (rr_picker), parametrised on NCH.
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int NCH = 3,
  parameter int GW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] valid,
  input  logic [GW-1:0]  ptr,
  output logic [GW-1:0]  pick,
  output logic           any
);

  assign pick = GW'(rr_pick(MAX_NCH'(valid), 3'(ptr), NCH));
  assign any  = |valid;

endmodule

// File: rtl/bus_arbiter.sv
// N-channel round-robin arbiter, one transaction in flight on the downstream port.
// Define BUS_ARBITER_BACK2BACK_EN to re-arbitrate on completion and skip the IDLE bubble.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int ADDR_W = 64,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SIZE_W = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCH-1:0]             s_valid,
  input  logic [NCH*ADDR_W-1:0]      s_addr,
  input  logic [NCH*SIZE_W-1:0]      s_size,
  input  logic [NCH*(DATA_W/8)-1:0]  s_strobe,
  input  logic [NCH*DATA_W-1:0]      s_wdata,
  output logic [NCH-1:0]             s_addr_ok,
  output logic [NCH-1:0]             s_data_ok,
  output logic [DATA_W-1:0]          s_rdata,
  output logic                       m_valid,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [SIZE_W-1:0]          m_size,
  output logic [DATA_W/8-1:0]        m_strobe,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic                       m_addr_ok,
  input  logic                       m_data_ok,
  input  logic [DATA_W-1:0]          m_rdata,
  output logic [$clog2(NCH)-1:0]     grant,
  output logic                       busy
);

  localparam int GW = $clog2(NCH);
  localparam int SW = DATA_W / 8;

  arb_state_t    state;
  logic [GW-1:0] ptr;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] pick;
  logic [GW-1:0] nxt_ptr;
  logic          any_req;
  logic          complete;

  rr_picker #(.NCH(NCH)) u_pick (
    .valid (s_valid),
    .ptr   (ptr),
    .pick  (pick),
    .any   (any_req)
  );

  // Explicit wrap so non-power-of-two channel counts never reach index NCH.
  assign nxt_ptr  = (grant_q == GW'(NCH - 1)) ? '0 : grant_q + 1'b1;
  assign complete = ((state == ADDR) && m_addr_ok && m_data_ok) ||
                    ((state == DATA) && m_data_ok);

`ifdef BUS_ARBITER_BACK2BACK_EN
  logic [NCH-1:0] b2b_valid;
  logic [GW-1:0]  b2b_pick;
  logic           b2b_any;

  always_comb begin
    b2b_valid          = s_valid;
    b2b_valid[grant_q] = 1'b0;
  end

  rr_picker #(.NCH(NCH)) u_b2b_pick (
    .valid (b2b_valid),
    .ptr   (nxt_ptr),
    .pick  (b2b_pick),
    .any   (b2b_any)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_q <= pick;
          state   <= ADDR;
        end
        ADDR: if (m_addr_ok && !m_data_ok) state <= DATA;
        default: ;
      endcase
      if (complete) begin
        ptr   <= nxt_ptr;
        state <= IDLE;
`ifdef BUS_ARBITER_BACK2BACK_EN
        if (b2b_any) begin
          grant_q <= b2b_pick;
          state   <= ADDR;
        end
`endif
      end
    end
  end

  assign grant   = grant_q;
  assign busy    = (state != IDLE);
  assign m_valid = (state == ADDR);
  assign s_rdata = m_rdata;

  // Fields follow the owner's live inputs; zero whenever no request is presented.
  assign m_addr   = m_valid ? s_addr[grant_q*ADDR_W +: ADDR_W]   : '0;
  assign m_size   = m_valid ? s_size[grant_q*SIZE_W +: SIZE_W]   : '0;
  assign m_strobe = m_valid ? s_strobe[grant_q*SW +: SW]         : '0;
  assign m_wdata  = m_valid ? s_wdata[grant_q*DATA_W +: DATA_W]  : '0;

  always_comb begin
    s_addr_ok = '0;
    s_data_ok = '0;
    if ((state == ADDR) && m_addr_ok) begin
      s_addr_ok[grant_q] = 1'b1;
      if (m_data_ok) s_data_ok[grant_q] = 1'b1;
    end
    if ((state == DATA) && m_data_ok) s_data_ok[grant_q] = 1'b1;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int NCH    = 3;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 3;
  localparam int SW     = DATA_W / 8;
  localparam int GW     = $clog2(NCH);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NCH-1:0]        s_valid;
  logic [ADDR_W-1:0]     ch_addr  [NCH];
  logic [SIZE_W-1:0]     ch_size  [NCH];
  logic [SW-1:0]         ch_strb  [NCH];
  logic [DATA_W-1:0]     ch_wdata [NCH];
  logic [NCH*ADDR_W-1:0] s_addr;
  logic [NCH*SIZE_W-1:0] s_size;
  logic [NCH*SW-1:0]     s_strobe;
  logic [NCH*DATA_W-1:0] s_wdata;
  logic [NCH-1:0]        s_addr_ok, s_data_ok;
  logic [DATA_W-1:0]     s_rdata;
  logic                  m_valid;
  logic [ADDR_W-1:0]     m_addr;
  logic [SIZE_W-1:0]     m_size;
  logic [SW-1:0]         m_strobe;
  logic [DATA_W-1:0]     m_wdata;
  logic                  m_addr_ok, m_data_ok;
  logic [DATA_W-1:0]     m_rdata;
  logic [GW-1:0]         grant;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign s_addr[g*ADDR_W +: ADDR_W]   = ch_addr[g];
    assign s_size[g*SIZE_W +: SIZE_W]   = ch_size[g];
    assign s_strobe[g*SW +: SW]         = ch_strb[g];
    assign s_wdata[g*DATA_W +: DATA_W]  = ch_wdata[g];
  end

  bus_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_addr(s_addr), .s_size(s_size), .s_strobe(s_strobe), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the bus, whether its address was taken, and where the search starts.
  int owner  = -1;
  int rr_ptr = 0;
  int last_g = 0;
  bit got_addr = 1'b0;

  function automatic int rr_first(input logic [NCH-1:0] v, input int p);
    for (int k = 0; k < NCH; k++) begin
      if (v[(p + k) % NCH]) return (p + k) % NCH;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic              e_mv;
    bit                done;
    int                w;
    logic [NCH-1:0]    e_sao, e_sdo, vmask;
    logic [ADDR_W-1:0] e_addr;
    logic [SIZE_W-1:0] e_size;
    logic [SW-1:0]     e_strb;
    logic [DATA_W-1:0] e_wdata;

    e_mv = (owner >= 0) && !got_addr;
    e_addr = '0; e_size = '0; e_strb = '0; e_wdata = '0;
    if (e_mv) begin
      e_addr = ch_addr[owner]; e_size = ch_size[owner];
      e_strb = ch_strb[owner]; e_wdata = ch_wdata[owner];
    end
    e_sao = '0;
    if (e_mv && m_addr_ok) e_sao[owner] = 1'b1;
    done = (owner >= 0) && m_data_ok && (got_addr || m_addr_ok);
    e_sdo = '0;
    if (done) e_sdo[owner] = 1'b1;

    chk("m_valid",   m_valid,   e_mv);
    chk("busy",      busy,      owner >= 0);
    chk("grant",     grant,     last_g);
    chk("m_addr",    m_addr,    e_addr);
    chk("m_size",    m_size,    e_size);
    chk("m_strobe",  m_strobe,  e_strb);
    chk("m_wdata",   m_wdata,   e_wdata);
    chk("s_addr_ok", s_addr_ok, e_sao);
    chk("s_data_ok", s_data_ok, e_sdo);
    chk("s_rdata",   s_rdata,   m_rdata);

    if (!reset) begin
      owner = -1; rr_ptr = 0; last_g = 0; got_addr = 1'b0;
    end else if (owner < 0) begin
      w = rr_first(s_valid, rr_ptr);
      if (w >= 0) begin owner = w; last_g = w; got_addr = 1'b0; end
    end else if (done) begin
      rr_ptr   = (owner + 1) % NCH;
      got_addr = 1'b0;
`ifdef BUS_ARBITER_BACK2BACK_EN
      vmask = s_valid;
      vmask[owner] = 1'b0;
      w = rr_first(vmask, rr_ptr);
      owner = w;
      if (w >= 0) last_g = w;
`else
      vmask = '0;
      owner = -1;
`endif
    end else if (e_mv && m_addr_ok) begin
      got_addr = 1'b1;
    end
  end

  logic [NCH-1:0] sao_q;
  always @(negedge clk) sao_q = s_addr_ok;

  initial begin
    reset = 1'b0; s_valid = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i] = '0; ch_size[i] = '0; ch_strb[i] = '0; ch_wdata[i] = '0;
    end
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_maddr", m_addr, 0);
    reset = 1'b1;

    // Single request on channel 1
    ch_addr[1] = 64'h8000_0010; ch_size[1] = 3'd3; s_valid = 3'b010;
    step();
    chk("t1_mvalid", m_valid, 1);
    chk("t1_grant", grant, 1);
    chk("t1_maddr", m_addr, 64'h8000_0010);
    chk("t1_msize", m_size, 3);
    m_addr_ok = 1'b1; #1;
    chk("t1_saok", s_addr_ok, 3'b010);
    chk("t1_sdok_early", s_data_ok, 3'b000);
    step(); m_addr_ok = 1'b0; s_valid = '0; #1;
    chk("t1_data_mvalid", m_valid, 0);
    chk("t1_data_busy", busy, 1);
    m_data_ok = 1'b1; m_rdata = 64'hDEAD_BEEF; #1;
    chk("t1_sdok", s_data_ok, 3'b010);
    chk("t1_rdata", s_rdata, 64'hDEAD_BEEF);
    step(); m_data_ok = 1'b0; #1;
    chk("t1_idle", busy, 0);

    // Pointer now 2: channel 2 beats channel 0; then same-cycle addr_ok+data_ok
    s_valid = 3'b101; step();
    chk("t2_grant", grant, 2);
    m_addr_ok = 1'b1; m_data_ok = 1'b1; s_valid = '0; #1;
    chk("t3_saok", s_addr_ok, 3'b100);
    chk("t3_sdok", s_data_ok, 3'b100);
    step(); m_addr_ok = 1'b0; m_data_ok = 1'b0; #1;
    chk("t3_no_data_state", busy, 0);

    // Channel 0 transaction moves the pointer to 1, then channel 2 enters DATA and is reset
    s_valid = 3'b001; step();
    m_addr_ok = 1'b1; m_data_ok = 1'b1; s_valid = '0; step();
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    s_valid = 3'b100; step();
    chk("t4_grant", grant, 2);
    m_addr_ok = 1'b1; s_valid = '0; step();
    m_addr_ok = 1'b0; reset = 1'b0; #1;
    chk("t4_in_data", busy, 1);
    step(); reset = 1'b1; m_data_ok = 1'b1; #1;
    chk("t4_sdok", s_data_ok, 3'b000);
    chk("t4_busy", busy, 0);
    chk("t4_grant_rst", grant, 0);
    m_addr_ok = 1'b1; step(); #1;
    chk("stray_sdok", s_data_ok, 3'b000);
    chk("stray_saok", s_addr_ok, 3'b000);
    chk("stray_busy", busy, 0);
    m_addr_ok = 1'b0; m_data_ok = 1'b0;

    // Continuous requests from all channels: pointer restarted at 0 by the reset
    s_valid = 3'b111; step();
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", grant, i % NCH);
      chk("rr_mvalid", m_valid, 1);
      m_addr_ok = 1'b1; step();
      m_addr_ok = 1'b0; m_data_ok = 1'b1; step();
      m_data_ok = 1'b0; #1;
`ifdef BUS_ARBITER_BACK2BACK_EN
      chk("b2b_no_gap", m_valid, 1);
`else
      chk("idle_gap_mvalid", m_valid, 0);
      chk("idle_gap_busy", busy, 0);
      if (i < 5) step();
`endif
    end
    s_valid = '0;
`ifdef BUS_ARBITER_BACK2BACK_EN
    m_addr_ok = 1'b1; m_data_ok = 1'b1; step();
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
`endif
    step();

    // Randomized traffic with stray responses, early drops and occasional resets
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < NCH; i++) begin
        if (s_valid[i]) begin
          if (sao_q[i] || ($urandom_range(0, 99) == 0)) s_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          s_valid[i]  = 1'b1;
          ch_addr[i]  = {$urandom, $urandom};
          ch_size[i]  = SIZE_W'($urandom);
          ch_strb[i]  = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
          ch_wdata[i] = {$urandom, $urandom};
        end
      end
      m_addr_ok = ($urandom_range(0, 2) == 0);
      m_data_ok = ($urandom_range(0, 2) == 0);
      m_rdata   = {$urandom, $urandom};
    end

    s_valid = '0; m_addr_ok = 1'b0; m_data_ok = 1'b0; reset = 1'b1;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
